// File: rtl/vsa_arb_pkg.sv
// Shared types and limits for the VSA data-memory arbiter.
// State encoding, default bus widths and read-latency bounds.
package vsa_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      ACK   = 2'd3
   } arb_state_t;

   localparam int DEF_AW     = 5;
   localparam int DEF_DW     = 5;
   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 4;
   localparam int CNT_W      = 2;

endpackage

// File: rtl/vsa_rr_pick2.sv
// Two-way round-robin picker for the data-memory arbiter.
// Purely combinational; the caller owns the last_grant history.
module vsa_rr_pick2 (
   input  logic [1:0] req,
   input  logic [1:0] mask,
   input  logic       last_grant,
   output logic       gnt_valid,
   output logic       gnt_id
);

   logic [1:0] live;

   assign live = req & ~mask;

   // A lone request wins outright; a tie goes to the port not served last.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_id    = 1'b0;
      unique case (live)
         2'b01: begin
            gnt_valid = 1'b1;
            gnt_id    = 1'b0;
         end
         2'b10: begin
            gnt_valid = 1'b1;
            gnt_id    = 1'b1;
         end
         2'b11: begin
            gnt_valid = 1'b1;
            gnt_id    = ~last_grant;
         end
         default: begin
            gnt_valid = 1'b0;
            gnt_id    = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/vsa_dmem_arbiter.sv
// Shares one single-port data RAM between two VSA requesters.
// One access in flight, round-robin on contention, one-cycle acks.
module vsa_dmem_arbiter
   import vsa_arb_pkg::*;
#(
   parameter int AW     = DEF_AW,
   parameter int DW     = DEF_DW,
   parameter int RD_LAT = 1
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          req0,
   input  logic          req1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   input  logic          wr0,
   input  logic          wr1,
   output logic          ack0,
   output logic          ack1,
   output logic [DW-1:0] rdata,
   output logic          mem_en,
   output logic          mem_wr,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   arb_state_t       state;
   arb_state_t       state_nx;
   logic             owner;
   logic             last_grant;
   logic             lat_wr;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       mask;
   logic             gnt_valid;
   logic             gnt_id;
   logic             take;

   // The owner's request is still high during its ack; hide it.
   assign mask = (state == ACK) ? (owner ? 2'b10 : 2'b01) : 2'b00;

   vsa_rr_pick2 u_pick (
      .req        ({req1, req0}),
      .mask       (mask),
      .last_grant (last_grant),
      .gnt_valid  (gnt_valid),
      .gnt_id     (gnt_id)
   );

   assign take = gnt_valid && (state == IDLE || state == ACK);

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   // Next-state selection.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (gnt_valid) state_nx = ISSUE;
         ISSUE:   state_nx = lat_wr ? ACK : WAIT;
         WAIT:    if (cnt == '0) state_nx = ACK;
         ACK:     state_nx = gnt_valid ? ISSUE : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Latch the winning request and pulse the memory strobe for it.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         owner     <= 1'b0;
         lat_wr    <= 1'b0;
         mem_en    <= 1'b0;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else if (take) begin
         owner     <= gnt_id;
         lat_wr    <= gnt_id ? wr1 : wr0;
         mem_en    <= 1'b1;
         mem_wr    <= gnt_id ? wr1 : wr0;
         mem_addr  <= gnt_id ? addr1 : addr0;
         mem_wdata <= gnt_id ? wdata1 : wdata0;
      end else begin
         mem_en    <= 1'b0;
         mem_wr    <= 1'b0;
      end
   end

   // Round-robin history and read-latency countdown.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         last_grant <= 1'b1;
         cnt        <= '0;
      end else if (state == ISSUE) begin
         last_grant <= owner;
         cnt        <= CNT_W'(RD_LAT - 1);
      end else if (state == WAIT && cnt != '0) begin
         cnt        <= cnt - 1'b1;
      end
   end

   // Read capture plus registered ack and busy flags.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rdata <= '0;
         ack0  <= 1'b0;
         ack1  <= 1'b0;
         busy  <= 1'b0;
      end else begin
         if (state == WAIT && cnt == '0) rdata <= mem_rdata;
         ack0 <= (state_nx == ACK) && !owner;
         ack1 <= (state_nx == ACK) && owner;
         busy <= (state_nx != IDLE);
      end
   end

   a_ack_onehot: assert property (@(posedge clock) disable iff (!reset_n)
      !(ack0 && ack1));

   a_en_issue: assert property (@(posedge clock) disable iff (!reset_n)
      mem_en |-> (state == ISSUE));

   a_state_legal: assert property (@(posedge clock) disable iff (!reset_n)
      state inside {IDLE, ISSUE, WAIT, ACK});

   a_req_held: assert property (@(posedge clock) disable iff (!reset_n)
      (state != IDLE) |-> (owner ? req1 : req0));

endmodule

// File: tb/tb_vsa_dmem_arbiter.sv
// Bench for vsa_dmem_arbiter: transaction-timeline model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_vsa_dmem_arbiter;

   localparam int RD_LAT = 2;

   typedef struct packed {
      logic       wr;
      logic [4:0] addr;
      logic [4:0] data;
   } op_t;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       req0 = 1'b0, req1 = 1'b0;
   logic [4:0] addr0 = '0, addr1 = '0;
   logic [4:0] wdata0 = '0, wdata1 = '0;
   logic       wr0 = 1'b0, wr1 = 1'b0;
   logic       ack0, ack1, mem_en, mem_wr, busy;
   logic [4:0] rdata, mem_addr, mem_wdata, mem_rdata;

   vsa_dmem_arbiter #(.AW(5), .DW(5), .RD_LAT(RD_LAT)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .req0      (req0),
      .req1      (req1),
      .addr0     (addr0),
      .addr1     (addr1),
      .wdata0    (wdata0),
      .wdata1    (wdata1),
      .wr0       (wr0),
      .wr1       (wr1),
      .ack0      (ack0),
      .ack1      (ack1),
      .rdata     (rdata),
      .mem_en    (mem_en),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   initial forever #5 clock = ~clock;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // ---------------- memory behind the arbiter ----------------
   logic [4:0] tb_mem [32];
   logic [4:0] pipe [RD_LAT];

   always @(posedge clock) begin
      if (mem_en && mem_wr) tb_mem[mem_addr] <= mem_wdata;
      if (mem_en) pipe[0] <= tb_mem[mem_addr];
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign mem_rdata = pipe[RD_LAT-1];

   int tcyc = 0;
   always @(posedge clock) tcyc <= tcyc + 1;

   // ---------------- requesters ----------------
   op_t q0[$];
   op_t q1[$];
   bit  act0 = 0, act1 = 0, kill = 0;
   int  rise0 = 0, rise1 = 0;

   initial begin : drv0
      op_t  op;
      logic seen;
      forever begin
         @(negedge clock);
         seen = ack0;
         @(posedge clock);
         #1;
         if (kill || seen) begin
            req0 = 1'b0;
            act0 = 0;
         end
         if (!act0 && !kill && q0.size() != 0) begin
            op = q0.pop_front();
            wr0 = op.wr; addr0 = op.addr; wdata0 = op.data;
            req0 = 1'b1; act0 = 1; rise0 = tcyc;
         end
      end
   end

   initial begin : drv1
      op_t  op;
      logic seen;
      forever begin
         @(negedge clock);
         seen = ack1;
         @(posedge clock);
         #1;
         if (kill || seen) begin
            req1 = 1'b0;
            act1 = 0;
         end
         if (!act1 && !kill && q1.size() != 0) begin
            op = q1.pop_front();
            wr1 = op.wr; addr1 = op.addr; wdata1 = op.data;
            req1 = 1'b1; act1 = 1; rise1 = tcyc;
         end
      end
   end

   // ---------------- transaction-timeline model ----------------
   // One access at a time: granted at the end of a free cycle, issued the
   // next cycle, acked 1 (write) or RD_LAT+1 (read) cycles after issue.
   logic [4:0] ref_mem [32];
   int         m_cyc = 0;
   bit         m_act = 0;
   int         m_port = 0;
   int         m_last = 1;
   int         m_issue = 0;
   int         m_ack = 0;
   int         pick = 0;
   bit         freed;
   logic [1:0] cand;
   logic       m_wr = 1'b0;
   logic [4:0] m_addr = '0, m_data = '0, m_rd = '0;
   logic [4:0] e_maddr = '0, e_mwdata = '0, e_rdata = '0;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_act = 0;
         m_last = 1;
         e_maddr = '0;
         e_mwdata = '0;
         e_rdata = '0;
      end else begin
         freed = !m_act || (m_cyc == m_ack);
         cand = {req1, req0};
         if (m_act && m_cyc == m_ack) cand[m_port] = 1'b0;
         if (freed) m_act = 0;
         if (freed && cand != 2'b00) begin
            pick = (cand == 2'b11) ? 1 - m_last : (cand[1] ? 1 : 0);
            m_act = 1;
            m_port = pick;
            m_last = pick;
            m_wr = pick ? wr1 : wr0;
            m_addr = pick ? addr1 : addr0;
            m_data = pick ? wdata1 : wdata0;
            m_issue = m_cyc + 1;
            m_ack = m_issue + (m_wr ? 1 : RD_LAT + 1);
         end
         m_cyc++;
         if (m_act && m_cyc == m_issue) begin
            e_maddr = m_addr;
            e_mwdata = m_data;
            if (m_wr) ref_mem[m_addr] = m_data;
            else m_rd = ref_mem[m_addr];
         end
         if (m_act && m_cyc == m_ack && !m_wr) e_rdata = m_rd;
      end
   end

   // ---------------- per-cycle compare and event log ----------------
   logic        e_en, e_ack0, e_ack1;
   logic [19:0] got_v, exp_v;
   int          served[$];
   int          ack_cyc_q[$];
   int          ack_rd_q[$];
   int          n_ack0 = 0, n_ack1 = 0, n_en = 0;
   int          en_cyc = 0;
   logic [4:0]  en_addr = '0, en_data = '0;
   logic        en_wr = 1'b0;

   always @(negedge clock) begin
      e_en   = m_act && (m_cyc == m_issue);
      e_ack0 = m_act && (m_cyc == m_ack) && (m_port == 0);
      e_ack1 = m_act && (m_cyc == m_ack) && (m_port == 1);
      exp_v = {e_ack0, e_ack1, m_act, e_en, e_en && m_wr,
               e_maddr, e_mwdata, e_rdata};
      got_v = {ack0, ack1, busy, mem_en, mem_wr,
               mem_addr, mem_wdata, rdata};
      check("cycle_outputs", 32'(got_v), 32'(exp_v));
      if (ack0 || ack1) begin
         served.push_back(ack1 ? 1 : 0);
         ack_cyc_q.push_back(tcyc);
         ack_rd_q.push_back(int'(rdata));
      end
      if (ack0) n_ack0++;
      if (ack1) n_ack1++;
      if (mem_en) begin
         n_en++;
         en_cyc = tcyc;
         en_addr = mem_addr;
         en_data = mem_wdata;
         en_wr = mem_wr;
      end
   end

   function automatic int srv(input int i);
      return (i < served.size()) ? served[i] : -1;
   endfunction

   function automatic int acyc(input int i);
      return (i < ack_cyc_q.size()) ? ack_cyc_q[i] : -1;
   endfunction

   function automatic int ard(input int i);
      return (i < ack_rd_q.size()) ? ack_rd_q[i] : -1;
   endfunction

   task automatic wait_idle(input string name);
      int n = 0;
      repeat (2) @(negedge clock);
      while (!(q0.size() == 0 && q1.size() == 0 && !act0 && !act1 && !busy)
             && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (n >= 200) check({name, "_timeout"}, 0, 1);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clock);
      #1 reset_n = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
      @(negedge clock);
      #1;
   endtask

   // ---------------- directed scenarios ----------------
   initial begin : main
      int b, a0, a1, ne, n;
      for (int i = 0; i < 32; i++) begin
         tb_mem[i] = 5'(i * 7 + 1);
         ref_mem[i] = 5'(i * 7 + 1);
      end
      tb_mem[3] = 5'h1F;
      ref_mem[3] = 5'h1F;

      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
      @(negedge clock);
      #1;
      check("reset_outputs",
            {ack0, ack1, busy, mem_en, mem_wr, rdata, mem_addr, mem_wdata},
            0);

      // single write on port 0
      b = served.size(); ne = n_en;
      q0.push_back('{1'b1, 5'h0A, 5'h15});
      wait_idle("wr");
      check("wr_en_count", n_en - ne, 1);
      check("wr_en_addr", en_addr, 5'h0A);
      check("wr_en_data", en_data, 5'h15);
      check("wr_en_wr", en_wr, 1);
      check("wr_port", srv(b), 0);
      check("wr_ack_latency", acyc(b) - rise0, 2);

      // single read on port 1
      b = served.size(); a0 = n_ack0;
      q1.push_back('{1'b0, 5'h03, 5'h00});
      wait_idle("rd");
      check("rd_port", srv(b), 1);
      check("rd_issue_to_ack", acyc(b) - en_cyc, 3);
      check("rd_data", ard(b), 5'h1F);
      check("rd_no_ack0", n_ack0 - a0, 0);

      // reset in the middle of a read
      ne = n_en; a1 = n_ack1; n = 0;
      q1.push_back('{1'b0, 5'h06, 5'h00});
      while (n_en == ne && n < 50) begin
         @(negedge clock);
         #1;
         n++;
      end
      if (n >= 50) check("rst_issue_timeout", 0, 1);
      @(posedge clock);
      #1;
      reset_n = 1'b0;
      kill = 1;
      @(negedge clock);
      #1;
      check("rst_mid_wait", {busy, mem_en, ack0, ack1}, 0);
      repeat (2) @(posedge clock);
      #2;
      kill = 0;
      reset_n = 1'b1;
      repeat (6) @(negedge clock);
      #1;
      check("rst_read_dropped", n_ack1 - a1, 0);

      // contention straight from reset
      do_reset();
      b = served.size();
      q0.push_back('{1'b1, 5'h01, 5'h02});
      q1.push_back('{1'b1, 5'h02, 5'h03});
      wait_idle("cont");
      check("cont_first", srv(b), 0);
      check("cont_second", srv(b + 1), 1);
      check("cont_back_to_back", acyc(b + 1) - acyc(b), 2);

      // fairness under continuous load
      do_reset();
      b = served.size();
      for (int i = 0; i < 3; i++) begin
         q0.push_back('{1'b1, 5'(8 + i), 5'(i + 1)});
         q1.push_back('{1'b1, 5'(16 + i), 5'(i + 9)});
      end
      wait_idle("fair");
      for (int i = 0; i < 6; i++) check($sformatf("fair_grant%0d", i),
                                        srv(b + i), i % 2);

      // read-after-write through the shared memory
      b = served.size();
      q1.push_back('{1'b0, 5'h03, 5'h00});
      wait_idle("raw_pre");
      check("raw_pre_rdata", ard(b), 5'h1F);
      b = served.size();
      q0.push_back('{1'b1, 5'h04, 5'h07});
      q1.push_back('{1'b0, 5'h04, 5'h00});
      wait_idle("raw");
      check("raw_order0", srv(b), 0);
      check("raw_rdata_hold", ard(b), 5'h1F);
      check("raw_order1", srv(b + 1), 1);
      check("raw_rdata", ard(b + 1), 5'h07);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

endmodule
